// File: rtl/eu_operand_cache.sv
// eu_operand_cache: per-unit result store with two local read ports
// and one interconnect read port; entries track read-before-overwrite.
module eu_operand_cache #(
  parameter int EU_IDX     = 0,
  parameter int IDX_BITS   = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int EU_BITS    = 4,
  localparam int TX_WIDTH  = ADDR_WIDTH + DATA_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_wr_valid,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  output logic                  o_wr_success,
  input  logic                  i_rd0_req,
  input  logic [ADDR_WIDTH-1:0] i_rd0_addr,
  output logic [DATA_WIDTH-1:0] o_rd0_data,
  output logic                  o_rd0_valid,
  input  logic                  i_rd1_req,
  input  logic [ADDR_WIDTH-1:0] i_rd1_addr,
  output logic [DATA_WIDTH-1:0] o_rd1_data,
  output logic                  o_rd1_valid,
  input  logic                  i_icon_req_valid,
  input  logic [ADDR_WIDTH-1:0] i_icon_req_addr,
  output logic                  o_icon_req_ready,
  output logic [TX_WIDTH-1:0]   o_icon_tx,
  input  logic                  i_icon_rx_success
);

  localparam int NUM_ENTRIES = 2 ** IDX_BITS;
  localparam int EU_LSB      = ADDR_WIDTH - EU_BITS;
  localparam logic [EU_BITS-1:0] MY_EU = EU_BITS'(EU_IDX);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_FULL  = 2'd1;
  localparam logic [1:0] ST_READ  = 2'd2;

  localparam logic [1:0] ICON_IDLE   = 2'd0;
  localparam logic [1:0] ICON_LOOKUP = 2'd1;
  localparam logic [1:0] ICON_SEND   = 2'd2;

  logic [DATA_WIDTH-1:0] mem_q [NUM_ENTRIES];
  logic [1:0]            st_q  [NUM_ENTRIES];
  logic [1:0]            st_d  [NUM_ENTRIES];

  logic [IDX_BITS-1:0] wr_idx, rd0_idx, rd1_idx, icon_idx;
  logic wr_ok, rd0_hit, rd1_hit, icon_hit;

  logic [1:0]            icon_q, icon_d;
  logic [ADDR_WIDTH-1:0] icon_addr_q, icon_addr_d;
  logic [TX_WIDTH-1:0]   tx_q, tx_d;

  logic                  rd0_valid_q, rd1_valid_q;
  logic [DATA_WIDTH-1:0] rd0_data_q, rd1_data_q;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_wr_addr[EU_LSB-1:IDX_BITS],
                              i_rd0_addr[ADDR_WIDTH-1:IDX_BITS],
                              i_rd1_addr[ADDR_WIDTH-1:IDX_BITS]};

  assign wr_idx   = i_wr_addr[IDX_BITS-1:0];
  assign rd0_idx  = i_rd0_addr[IDX_BITS-1:0];
  assign rd1_idx  = i_rd1_addr[IDX_BITS-1:0];
  assign icon_idx = icon_addr_q[IDX_BITS-1:0];

  assign wr_ok = i_wr_valid
              && (i_wr_addr[ADDR_WIDTH-1:EU_LSB] == MY_EU)
              && (st_q[wr_idx] != ST_FULL);
  assign rd0_hit  = i_rd0_req && (st_q[rd0_idx] != ST_EMPTY);
  assign rd1_hit  = i_rd1_req && (st_q[rd1_idx] != ST_EMPTY);
  assign icon_hit = (icon_q == ICON_LOOKUP)
                 && (st_q[icon_idx] != ST_EMPTY);

  assign o_wr_success     = wr_ok;
  assign o_rd0_valid      = rd0_valid_q;
  assign o_rd0_data       = rd0_data_q;
  assign o_rd1_valid      = rd1_valid_q;
  assign o_rd1_data       = rd1_data_q;
  assign o_icon_tx        = tx_q;
  assign o_icon_req_ready = (icon_q == ICON_IDLE);

  // Entry state update: an accepted write wins over any same-cycle read.
  always_comb begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      st_d[i] = st_q[i];
      if (wr_ok && wr_idx == IDX_BITS'(i)) begin
        st_d[i] = ST_FULL;
      end else if (st_q[i] == ST_FULL &&
                   ((rd0_hit && rd0_idx == IDX_BITS'(i)) ||
                    (rd1_hit && rd1_idx == IDX_BITS'(i)) ||
                    (icon_hit && icon_idx == IDX_BITS'(i)))) begin
        st_d[i] = ST_READ;
      end
    end
  end

  // Interconnect read FSM: latch request, wait for data, hold until taken.
  always_comb begin
    icon_d      = icon_q;
    icon_addr_d = icon_addr_q;
    tx_d        = tx_q;
    unique case (1'b1)
      (icon_q == ICON_IDLE): begin
        if (i_icon_req_valid &&
            i_icon_req_addr[ADDR_WIDTH-1:EU_LSB] == MY_EU) begin
          icon_addr_d = i_icon_req_addr;
          icon_d      = ICON_LOOKUP;
        end
      end
      (icon_q == ICON_LOOKUP): begin
        if (icon_hit) begin
          tx_d   = {icon_addr_q, mem_q[icon_idx], 1'b1};
          icon_d = ICON_SEND;
        end
      end
      (icon_q == ICON_SEND): begin
        if (i_icon_rx_success) begin
          tx_d[0] = 1'b0;
          icon_d  = ICON_IDLE;
        end
      end
      default: icon_d = ICON_IDLE;
    endcase
  end

  // Data RAM carries no reset; entry state alone says what is valid.
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_idx] <= i_wr_data;
  end

  // Entry state, read ports and interconnect registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_ENTRIES; i++) st_q[i] <= ST_EMPTY;
      rd0_valid_q <= 1'b0;
      rd1_valid_q <= 1'b0;
      rd0_data_q  <= '0;
      rd1_data_q  <= '0;
      icon_q      <= ICON_IDLE;
      icon_addr_q <= '0;
      tx_q        <= '0;
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) st_q[i] <= st_d[i];
      rd0_valid_q <= rd0_hit;
      rd1_valid_q <= rd1_hit;
      if (rd0_hit) rd0_data_q <= mem_q[rd0_idx];
      if (rd1_hit) rd1_data_q <= mem_q[rd1_idx];
      icon_q      <= icon_d;
      icon_addr_q <= icon_addr_d;
      tx_q        <= tx_d;
    end
  end

endmodule

// File: tb/tb_eu_operand_cache.sv
// tb_eu_operand_cache: vector table, hand-written icon/reset sequences,
// then random traffic against a behavioural model.
module tb_eu_operand_cache;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int TW = AW + DW + 1;

  logic clk = 1'b0;
  logic reset_n;
  logic wr_valid, rd0_req, rd1_req, icon_req_valid, icon_rx_success;
  logic [AW-1:0] wr_addr, rd0_addr, rd1_addr, icon_req_addr;
  logic [DW-1:0] wr_data;
  logic wr_success, rd0_valid, rd1_valid, icon_req_ready;
  logic [DW-1:0] rd0_data, rd1_data;
  logic [TW-1:0] icon_tx;

  always #5 clk = ~clk;

  eu_operand_cache #(.EU_IDX(0), .IDX_BITS(4), .DATA_WIDTH(DW),
                     .ADDR_WIDTH(AW), .EU_BITS(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_wr_valid(wr_valid), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .o_wr_success(wr_success),
    .i_rd0_req(rd0_req), .i_rd0_addr(rd0_addr),
    .o_rd0_data(rd0_data), .o_rd0_valid(rd0_valid),
    .i_rd1_req(rd1_req), .i_rd1_addr(rd1_addr),
    .o_rd1_data(rd1_data), .o_rd1_valid(rd1_valid),
    .i_icon_req_valid(icon_req_valid), .i_icon_req_addr(icon_req_addr),
    .o_icon_req_ready(icon_req_ready), .o_icon_tx(icon_tx),
    .i_icon_rx_success(icon_rx_success)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [AW-1:0] mk(int eu, int uid, int sp);
    return {4'(eu), 10'(uid), 2'(sp)};
  endfunction

  task automatic idle_in();
    wr_valid = 0; wr_addr = '0; wr_data = '0;
    rd0_req = 0; rd0_addr = '0; rd1_req = 0; rd1_addr = '0;
    icon_req_valid = 0; icon_req_addr = '0; icon_rx_success = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_in();
    reset_n = 0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic          wv;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic          r0;
    logic [AW-1:0] a0;
    logic          r1;
    logic [AW-1:0] a1;
    logic          ok;
    logic          v0;
    logic [DW-1:0] d0;
    logic          v1;
    logic [DW-1:0] d1;
  } vec_t;

  vec_t tbl[12];

  // behavioural model
  logic [DW-1:0] m_data [16];
  bit            m_has [16];
  bit            m_unread [16];
  int            m_phase;
  logic [AW-1:0] m_lat;
  logic [TW-1:0] m_tx;
  logic          m_v0, m_v1;
  logic [DW-1:0] m_d0, m_d1;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_has[i] = 0; m_unread[i] = 0; m_data[i] = '0;
    end
    m_phase = 0; m_lat = '0; m_tx = '0;
    m_v0 = 0; m_v1 = 0; m_d0 = '0; m_d1 = '0;
  endtask

  function automatic bit model_wr_ok();
    int i;
    i = int'(wr_addr[3:0]);
    return wr_valid && wr_addr[15:12] == 4'd0
        && !(m_has[i] && m_unread[i]);
  endfunction

  task automatic model_edge();
    bit ok;
    int i0, i1, iw, il;
    bit take[16];
    ok = model_wr_ok();
    i0 = int'(rd0_addr[3:0]);
    i1 = int'(rd1_addr[3:0]);
    iw = int'(wr_addr[3:0]);
    il = int'(m_lat[3:0]);
    for (int i = 0; i < 16; i++) take[i] = 0;
    m_v0 = rd0_req && m_has[i0];
    if (m_v0) begin m_d0 = m_data[i0]; take[i0] = 1; end
    m_v1 = rd1_req && m_has[i1];
    if (m_v1) begin m_d1 = m_data[i1]; take[i1] = 1; end
    if (m_phase == 0) begin
      if (icon_req_valid && icon_req_addr[15:12] == 4'd0) begin
        m_lat = icon_req_addr;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (m_has[il]) begin
        m_tx = {m_lat, m_data[il], 1'b1};
        take[il] = 1;
        m_phase = 2;
      end
    end else if (icon_rx_success) begin
      m_tx[0] = 1'b0;
      m_phase = 0;
    end
    for (int i = 0; i < 16; i++) if (take[i]) m_unread[i] = 0;
    if (ok) begin
      m_data[iw] = wr_data; m_has[iw] = 1; m_unread[iw] = 1;
    end
  endtask

  logic [AW-1:0] a_ic, a_rs;

  initial begin
    idle_in();
    reset_n = 0;
    #22;
    chk("rst_wr_ok", 64'(wr_success), 0);
    chk("rst_rd0_valid", 64'(rd0_valid), 0);
    chk("rst_rd0_data", 64'(rd0_data), 0);
    chk("rst_rd1_valid", 64'(rd1_valid), 0);
    chk("rst_rd1_data", 64'(rd1_data), 0);
    chk("rst_icon_tx", 64'(icon_tx), 0);
    chk("rst_ready", 64'(icon_req_ready), 1);
    do_reset();

    tbl[0]  = '{1, mk(0,1,2), 16'h00AB, 0, '0, 0, '0,
                1, 0, 16'h0000, 0, 16'h0000};
    tbl[1]  = '{0, '0, '0, 1, mk(0,1,2), 0, '0,
                0, 1, 16'h00AB, 0, 16'h0000};
    tbl[2]  = '{1, mk(0,3,1), 16'h1111, 0, '0, 0, '0,
                1, 0, 16'h00AB, 0, 16'h0000};
    tbl[3]  = '{1, mk(0,3,1), 16'h2222, 0, '0, 0, '0,
                0, 0, 16'h00AB, 0, 16'h0000};
    tbl[4]  = '{0, '0, '0, 0, '0, 1, mk(0,3,1),
                0, 0, 16'h00AB, 1, 16'h1111};
    tbl[5]  = '{1, mk(0,3,1), 16'h2222, 0, '0, 0, '0,
                1, 0, 16'h00AB, 0, 16'h1111};
    tbl[6]  = '{0, '0, '0, 1, mk(0,3,1), 0, '0,
                0, 1, 16'h2222, 0, 16'h1111};
    tbl[7]  = '{1, mk(1,0,0), 16'h5555, 0, '0, 0, '0,
                0, 0, 16'h2222, 0, 16'h1111};
    tbl[8]  = '{0, '0, '0, 1, mk(0,0,0), 0, '0,
                0, 0, 16'h2222, 0, 16'h1111};
    tbl[9]  = '{1, mk(0,3,1), 16'h3333, 1, mk(0,3,1), 0, '0,
                1, 1, 16'h2222, 0, 16'h1111};
    tbl[10] = '{0, '0, '0, 1, mk(0,3,1), 1, mk(0,7,1),
                0, 1, 16'h3333, 1, 16'h3333};
    tbl[11] = '{0, '0, '0, 1, mk(0,0,0), 1, mk(0,1,2),
                0, 0, 16'h3333, 1, 16'h00AB};

    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      wr_valid = tbl[k].wv; wr_addr = tbl[k].wa; wr_data = tbl[k].wd;
      rd0_req = tbl[k].r0; rd0_addr = tbl[k].a0;
      rd1_req = tbl[k].r1; rd1_addr = tbl[k].a1;
      #1;
      chk($sformatf("t%0d_wr_ok", k), 64'(wr_success), 64'(tbl[k].ok));
      tick();
      chk($sformatf("t%0d_rd0_valid", k), 64'(rd0_valid), 64'(tbl[k].v0));
      chk($sformatf("t%0d_rd0_data", k), 64'(rd0_data), 64'(tbl[k].d0));
      chk($sformatf("t%0d_rd1_valid", k), 64'(rd1_valid), 64'(tbl[k].v1));
      chk($sformatf("t%0d_rd1_data", k), 64'(rd1_data), 64'(tbl[k].d1));
    end

    // icon: wrong euidx dropped, then request to an empty entry
    do_reset();
    icon_req_valid = 1; icon_req_addr = mk(1,2,0);
    tick();
    chk("ic_drop_ready", 64'(icon_req_ready), 1);
    a_ic = mk(0,2,0);
    @(negedge clk);
    icon_req_addr = a_ic;
    tick();
    chk("ic_lookup_ready", 64'(icon_req_ready), 0);
    @(negedge clk);
    icon_req_valid = 0;
    tick();
    tick();
    chk("ic_wait_valid", 64'(icon_tx[0]), 0);
    @(negedge clk);
    wr_valid = 1; wr_addr = a_ic; wr_data = 16'h0F0F;
    #1;
    chk("ic_wr_ok", 64'(wr_success), 1);
    tick();
    chk("ic_after_wr_valid", 64'(icon_tx[0]), 0);
    @(negedge clk);
    wr_valid = 0;
    tick();
    chk("ic_tx", 64'(icon_tx), 64'({a_ic, 16'h0F0F, 1'b1}));
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("ic_hold%0d", k), 64'(icon_tx),
          64'({a_ic, 16'h0F0F, 1'b1}));
      chk($sformatf("ic_hold_ready%0d", k), 64'(icon_req_ready), 0);
    end
    @(negedge clk);
    icon_rx_success = 1;
    tick();
    chk("ic_done_valid", 64'(icon_tx[0]), 0);
    chk("ic_done_ready", 64'(icon_req_ready), 1);
    @(negedge clk);
    icon_rx_success = 0;
    wr_valid = 1; wr_addr = a_ic; wr_data = 16'h1234;
    #1;
    chk("ic_entry_read_wr_ok", 64'(wr_success), 1);
    tick();

    // reset while sending
    a_rs = mk(0,4,0);
    @(negedge clk);
    wr_valid = 1; wr_addr = a_rs; wr_data = 16'hBEEF;
    icon_req_valid = 1; icon_req_addr = a_rs;
    tick();
    @(negedge clk);
    wr_valid = 0; icon_req_valid = 0;
    tick();
    chk("rs_send_tx", 64'(icon_tx), 64'({a_rs, 16'hBEEF, 1'b1}));
    #2;
    reset_n = 0;
    #1;
    chk("rs_async_tx", 64'(icon_tx), 0);
    chk("rs_async_ready", 64'(icon_req_ready), 1);
    @(negedge clk);
    reset_n = 1;
    rd0_req = 1; rd0_addr = a_rs;
    tick();
    chk("rs_rd_miss", 64'(rd0_valid), 0);
    chk("rs_rd_data", 64'(rd0_data), 0);

    // random traffic against the model
    do_reset();
    model_reset();
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      wr_valid = ($urandom_range(0, 1) == 1);
      wr_addr = mk(($urandom_range(0, 3) == 0) ? 1 : 0,
                   $urandom_range(0, 7), $urandom_range(0, 3));
      wr_data = 16'($urandom);
      rd0_req = ($urandom_range(0, 2) != 0);
      rd0_addr = mk($urandom_range(0, 1), $urandom_range(0, 7),
                    $urandom_range(0, 3));
      rd1_req = ($urandom_range(0, 2) != 0);
      rd1_addr = mk($urandom_range(0, 1), $urandom_range(0, 7),
                    $urandom_range(0, 3));
      icon_req_valid = ($urandom_range(0, 3) == 0);
      icon_req_addr = mk(($urandom_range(0, 3) == 0) ? 1 : 0,
                         $urandom_range(0, 7), $urandom_range(0, 3));
      icon_rx_success = ($urandom_range(0, 2) == 0);
      #1;
      chk("rnd_wr_ok", 64'(wr_success), 64'(model_wr_ok()));
      model_edge();
      tick();
      chk("rnd_rd0_valid", 64'(rd0_valid), 64'(m_v0));
      chk("rnd_rd0_data", 64'(rd0_data), 64'(m_d0));
      chk("rnd_rd1_valid", 64'(rd1_valid), 64'(m_v1));
      chk("rnd_rd1_data", 64'(rd1_data), 64'(m_d1));
      chk("rnd_icon_tx", 64'(icon_tx), 64'(m_tx));
      chk("rnd_ready", 64'(icon_req_ready), 64'(m_phase == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
